// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run controller.
//   state_t      : sequencer states IDLE..HALT
//   *_DEF        : default widths and the halt opcode used by core_run_ctrl
package core_ctrl_pkg;

  localparam int         PC_W_DEF     = 6;
  localparam int         XLEN_DEF     = 32;
  localparam int         CNT_W_DEF    = 32;
  localparam logic [6:0] HALT_OPC_DEF = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRIME,
    ST_RUN,
    ST_PAUSE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer for a single-cycle datapath and its instruction memory.
// Owns the PC presented to imem, forwards program-load beats to the imem write
// port, primes the registered-address imem for one cycle before running, gates
// datapath commits through core_en, stops on the halt opcode or a misaligned
// next PC, and counts retired instructions.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, step, abort         control pulses (run from 0 / retire one / to IDLE)
//   load_valid/ready/last      program-load handshake; load_addr/load_data beat
//   instruction, nPc           imem read data and datapath next-PC byte address
//   pc                         word address to imem
//   imem_we/waddr/wdata        imem write port
//   core_en                    datapath may commit this cycle
//   halted, err, retire_cnt    status: halt reached, misaligned nPc, retired count
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int         PC_W     = PC_W_DEF,
  parameter int         XLEN     = XLEN_DEF,
  parameter logic [6:0] HALT_OPC = HALT_OPC_DEF,
  parameter int         CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             load_last,
  input  logic [PC_W-1:0]  load_addr,
  input  logic [XLEN-1:0]  load_data,
  input  logic [XLEN-1:0]  instruction,
  input  logic [XLEN-1:0]  nPc,
  output logic [PC_W-1:0]  pc,
  output logic             imem_we,
  output logic [PC_W-1:0]  imem_waddr,
  output logic [XLEN-1:0]  imem_wdata,
  output logic             core_en,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t           state_reg, state_next;
  logic             single_reg, single_next;   // 1: RUN retires one word then PAUSE
  logic [PC_W-1:0]  pc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             halted_reg;
  logic             is_halt;
  logic             misaligned;

  // Only the word-address slice of nPc and the opcode field are consumed.
  logic unused_bits;
  assign unused_bits = ^{nPc[XLEN-1:PC_W+2], instruction[XLEN-1:7]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      single_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      single_reg <= single_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    single_next = single_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load_valid) begin
            state_next = ST_LOAD;
          end else if (start) begin
            state_next  = ST_PRIME;
            single_next = 1'b0;
          end else if (step) begin
            state_next  = ST_PRIME;
            single_next = 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_valid && load_last) state_next = ST_IDLE;
        end
        ST_PRIME: state_next = ST_RUN;
        ST_RUN: begin
          // A misaligned nPc still commits; the error wins over single-step pause.
          if (is_halt || misaligned) state_next = ST_HALT;
          else if (single_reg)       state_next = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start) begin
            state_next  = ST_PRIME;
            single_next = 1'b0;
          end else if (step) begin
            state_next = ST_RUN;
          end
        end
        ST_HALT: begin
          if (load_valid) begin
            state_next = ST_LOAD;
          end else if (start) begin
            state_next  = ST_PRIME;
            single_next = 1'b0;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic. Strobes are masked during reset/abort so the in-flight
  // beat or instruction is dropped rather than committed.
  always_comb begin
    is_halt    = (instruction[6:0] == HALT_OPC);
    misaligned = (nPc[1:0] != 2'b00);
    core_en    = rst_n & ~abort & (state_reg == ST_RUN) & ~is_halt;
    imem_we    = rst_n & ~abort & (state_reg == ST_LOAD) & load_valid;
  end

  // PC, retire counter and status flags
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      pc_reg     <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= (state_next == ST_HALT);
      if (state_next == ST_PRIME) begin
        pc_reg  <= '0;
        cnt_reg <= '0;
        err_reg <= 1'b0;
      end else if (core_en) begin
        if (cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
        if (misaligned) err_reg <= 1'b1;
        else            pc_reg  <= nPc[PC_W+1:2];
      end
    end
  end

  assign load_ready = (state_reg == ST_LOAD);
  assign imem_waddr = load_addr;
  assign imem_wdata = load_data;
  assign pc         = pc_reg;
  assign retire_cnt = cnt_reg;
  assign err        = err_reg;
  assign halted     = halted_reg;

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

  localparam int PCW = 6;
  localparam int XL  = 32;
  localparam int CW  = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, step = 1'b0, abort = 1'b0;
  logic           load_valid = 1'b0, load_last = 1'b0;
  logic [PCW-1:0] load_addr = '0;
  logic [XL-1:0]  load_data = '0;
  logic [XL-1:0]  instruction, nPc;
  logic [PCW-1:0] pc, imem_waddr;
  logic           load_ready, imem_we, core_en, halted, err;
  logic [XL-1:0]  imem_wdata;
  logic [CW-1:0]  retire_cnt;

  // Bench-side instruction memory and next-PC source
  logic [XL-1:0]  mem [64];
  logic           use_mem = 1'b1;
  logic [XL-1:0]  rnd_instr = '0;
  logic           npc_ovr_en = 1'b0;
  logic [XL-1:0]  npc_ovr = '0;

  assign instruction = use_mem ? mem[pc] : rnd_instr;
  assign nPc = npc_ovr_en ? npc_ovr : (({26'b0, pc} + 32'd1) << 2);

  core_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready), .load_last(load_last),
    .load_addr(load_addr), .load_data(load_data), .instruction(instruction),
    .nPc(nPc), .pc(pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_en(core_en), .halted(halted), .err(err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;
  int ce_count = 0;
  bit comb_ok  = 0;

  // Reference model: phase of the sequencer plus architectural counters.
  typedef enum {PH_IDLE, PH_LOAD, PH_PRIME, PH_RUN, PH_PAUSE, PH_HALT} ph_t;
  ph_t     m_ph = PH_IDLE;
  bit      m_single = 0;
  int      m_pc = 0;
  longint  m_cnt = 0;
  bit      m_err = 0;
  localparam longint CNT_MAX = (64'd1 << CW) - 1;

  logic [XL-1:0] prog1 [19];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_prime(input bit single);
    m_ph = PH_PRIME; m_single = single; m_pc = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit r, input bit ab, input bit st, input bit sp,
                            input bit lv, input bit ll, input logic [6:0] opc,
                            input longint npc);
    if (!r || ab) begin
      m_ph = PH_IDLE; m_pc = 0; m_cnt = 0; m_err = 0;
      return;
    end
    case (m_ph)
      PH_IDLE:  if (lv) m_ph = PH_LOAD; else if (st || sp) m_prime(!st);
      PH_LOAD:  if (lv && ll) m_ph = PH_IDLE;
      PH_PRIME: m_ph = PH_RUN;
      PH_RUN: begin
        if (opc == 7'h7F) m_ph = PH_HALT;
        else begin
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          if (npc % 4 != 0) begin
            m_err = 1; m_ph = PH_HALT;
          end else begin
            m_pc = int'((npc / 4) % 64);
            if (m_single) m_ph = PH_PAUSE;
          end
        end
      end
      PH_PAUSE: if (st) m_prime(0); else if (sp) m_ph = PH_RUN;
      PH_HALT:  if (lv) m_ph = PH_LOAD; else if (st) m_prime(0);
      default:  m_ph = PH_IDLE;
    endcase
  endtask

  // One clock: check combinational outputs before the edge, advance the
  // model and the bench imem at the edge, check registered outputs after.
  task automatic tick();
    bit exp_ce, exp_we, c_we, c_ce;
    logic [6:0] opc;
    longint npc;
    logic [PCW-1:0] wa;
    logic [XL-1:0] wd;
    #1;
    opc = instruction[6:0];
    npc = longint'(nPc);
    exp_ce = rst_n && !abort && m_ph == PH_RUN && opc != 7'h7F;
    exp_we = rst_n && !abort && m_ph == PH_LOAD && load_valid;
    if (comb_ok) begin
      check_val("core_en", core_en, exp_ce);
      check_val("imem_we", imem_we, exp_we);
      check_val("load_ready", load_ready, m_ph == PH_LOAD);
      if (exp_we) begin
        check_val("imem_waddr", imem_waddr, load_addr);
        check_val("imem_wdata", imem_wdata, load_data);
      end
    end
    c_we = imem_we; c_ce = core_en; wa = imem_waddr; wd = imem_wdata;
    @(posedge clk);
    if (c_we === 1'b1) begin mem[wa] = wd; we_count++; end
    if (c_ce === 1'b1) ce_count++;
    model_edge(rst_n, abort, start, step, load_valid, load_last, opc, npc);
    @(negedge clk);
    comb_ok = 1;
    check_val("pc", pc, m_pc);
    check_val("retire_cnt", retire_cnt, m_cnt);
    check_val("err", err, m_err);
    check_val("halted", halted, m_ph == PH_HALT);
  endtask

  task automatic load_burst(input int n, input int base, input logic [XL-1:0] word0,
                            input bit fixed);
    int beat = 0;
    int budget = 4 * n + 8;
    while (beat < n && budget > 0) begin
      bit rdy;
      load_valid = 1'b1;
      load_addr  = PCW'(base + beat);
      load_data  = fixed ? word0 : prog1[beat];
      load_last  = (beat == n - 1);
      rdy = (m_ph == PH_LOAD);
      tick();
      if (rdy) begin
        $display("load beat addr=%0d data=0x%08h", base + beat, load_data);
        beat++;
      end
      budget--;
    end
    load_valid = 1'b0; load_last = 1'b0;
    if (beat < n) check_val("load_timeout", beat, n);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) tick();
    check_val("halt_reached", halted, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_007F;
    prog1[0] = 32'h0060_0513;
    prog1[1] = 32'h0000_007F;
    for (int i = 2; i < 19; i++) prog1[i] = {$urandom() % (1 << 25), 7'h13};

    @(negedge clk);
    rst_n = 1'b0;
    tick(); tick();
    check_val("rst_pc", pc, 0);
    check_val("rst_core_en", core_en, 0);
    check_val("rst_load_ready", load_ready, 0);
    rst_n = 1'b1;

    // Program load and read-back
    we_count = 0;
    load_burst(19, 0, '0, 0);
    check_val("load_we_pulses", we_count, 19);
    for (int i = 0; i < 19; i++) check_val("readback", mem[i], prog1[i]);
    tick(); tick();

    // Run to the halt word
    start = 1'b1; tick(); start = 1'b0;
    $display("start: run from pc 0");
    wait_halt(20);
    check_val("run_retire", retire_cnt, 1);
    check_val("run_pc", pc, 1);
    tick(); tick();
    check_val("halt_pc_held", pc, 1);

    // Straight-line program, single-stepped three times
    load_burst(4, 0, 32'h0000_0013, 1);
    ce_count = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1; tick(); step = 1'b0;
      tick(); tick(); tick();
      $display("step %0d: pc=%0d retire_cnt=%0d", s, pc, retire_cnt);
    end
    check_val("step_ce_pulses", ce_count, 3);
    check_val("step_pc", pc, 3);
    tick(); tick(); tick();
    check_val("pause_no_commit", ce_count, 3);

    // Misaligned next PC
    abort = 1'b1; tick(); abort = 1'b0;
    npc_ovr_en = 1'b1; npc_ovr = 32'h0000_0102;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    $display("misaligned nPc: err=%0d halted=%0d pc=%0d", err, halted, pc);
    check_val("mis_err", err, 1);
    check_val("mis_halted", halted, 1);
    check_val("mis_pc", pc, 0);

    // PC wrap, then abort mid-run
    npc_ovr = 32'h0000_0104;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check_val("wrap_pc", pc, 1);
    check_val("wrap_err", err, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    $display("abort mid-run: pc=%0d retire_cnt=%0d", pc, retire_cnt);
    check_val("abort_pc", pc, 0);
    check_val("abort_cnt", retire_cnt, 0);
    tick();
    npc_ovr_en = 1'b0;

    // Reset in the middle of a load burst
    we_count = 0;
    load_valid = 1'b1; load_data = 32'h0000_0013; load_last = 1'b0;
    load_addr = 6'd4; tick(); tick();
    load_addr = 6'd5; tick();
    load_addr = 6'd6; rst_n = 1'b0; tick();
    rst_n = 1'b1; load_valid = 1'b0; tick();
    $display("reset mid-load: %0d beats written", we_count);
    check_val("rst_load_we", we_count, 2);
    check_val("rst_load_idle_ready", load_ready, 0);

    // start and step together select run mode
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    wait_halt(40);
    $display("run mode: retire_cnt=%0d pc=%0d", retire_cnt, pc);
    check_val("both_retire", retire_cnt, 19);
    check_val("both_pc", pc, 19);

    // load_valid beats start while halted
    load_valid = 1'b1; start = 1'b1; load_addr = 6'd20;
    load_data = 32'h0000_007F; load_last = 1'b1;
    tick(); start = 1'b0;
    check_val("halt_to_load", load_ready, 1);
    tick(); load_valid = 1'b0; load_last = 1'b0; tick();

    // Randomized phase
    use_mem = 1'b0; npc_ovr_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      abort      = ($urandom_range(0, 39) == 0);
      start      = ($urandom_range(0, 19) == 0);
      step       = ($urandom_range(0, 7) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_last  = ($urandom_range(0, 3) == 0);
      load_addr  = PCW'($urandom());
      load_data  = $urandom();
      rnd_instr  = ($urandom_range(0, 7) == 0) ? 32'h0000_007F : {$urandom() % (1 << 25), 7'h33};
      npc_ovr    = $urandom();
      if ($urandom_range(0, 9) != 0) npc_ovr[1:0] = 2'b00;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
